// File: rtl/jtshouse_scr_romrd_if.sv
// jtshouse_scr_romrd_if
//   Bus bundle between the scroll tile reader, the two-entry ROM word cache
//   and the SDRAM word port.
//   Signals:
//     flush     cache invalidate (ROM download or bank change)
//     scr_cs    tile-reader request valid
//     scr_addr  tile-reader byte address [AW-1:0]
//     scr_data  returned byte
//     scr_ok    scr_data valid for the current scr_addr
//     rom_cs    SDRAM word request
//     rom_addr  SDRAM 32-bit word address [AW-3:0]
//     rom_data  SDRAM word, byte 0 in [7:0]
//     rom_ok    SDRAM data valid
//   Modports:
//     master  environment side (tile reader + SDRAM controller)
//     slave   cache side
interface jtshouse_scr_romrd_if #(
  parameter int AW = 20
);
  logic          flush;
  logic          scr_cs;
  logic [AW-1:0] scr_addr;
  logic [7:0]    scr_data;
  logic          scr_ok;
  logic          rom_cs;
  logic [AW-3:0] rom_addr;
  logic [31:0]   rom_data;
  logic          rom_ok;

  modport master (
    output flush, scr_cs, scr_addr, rom_data, rom_ok,
    input  scr_data, scr_ok, rom_cs, rom_addr
  );

  modport slave (
    input  flush, scr_cs, scr_addr, rom_data, rom_ok,
    output scr_data, scr_ok, rom_cs, rom_addr
  );
endinterface

// File: rtl/jtshouse_scr_romrd.sv
// jtshouse_scr_romrd
//   Two-entry 32-bit word cache between the scroll tile reader and SDRAM,
//   with optional sequential next-word prefetch.
//   Ports:
//     clk    single clock, rising edge
//     rst_n  synchronous active-low reset
//     bus    jtshouse_scr_romrd_if.slave (scr_* request side, rom_* SDRAM side, flush)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no SDRAM access; evaluate hit/miss and prefetch
//   FETCH | demand fill of a missed word in flight
//   PREF  | prefetch of the word after the current one in flight
module jtshouse_scr_romrd #(
  parameter int PREFETCH = 1,
  parameter int AW       = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  jtshouse_scr_romrd_if.slave   bus
);

  localparam int TW = AW - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PREF  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;

  logic [1:0]      r_valid;
  logic [TW-1:0]   r_tag [2];
  logic [31:0]     r_word [2];
  logic            r_lru;
  logic            r_rom_cs;
  logic [TW-1:0]   r_rom_addr;
  logic [7:0]      r_scr_data;
  logic            r_ok;
  logic [AW-1:0]   r_addr_l;
  logic            r_first;
  logic            r_discard;

  logic [TW-1:0]   w_cur_tag;
  logic [TW-1:0]   w_nxt_tag;
  logic            w_hit0;
  logic            w_hit1;
  logic            w_hit;
  logic            w_hit_idx;
  logic            w_nxt_in;
  logic            w_scr_ok;
  logic            w_miss;
  logic            w_ack;
  logic            w_fill;
  logic            w_victim;
  logic [31:0]     w_hit_word;
  logic [7:0]      w_byte;
  logic            w_start;
  logic [TW-1:0]   w_start_addr;

  assign w_cur_tag = bus.scr_addr[AW-1:2];
  // Wraps naturally at the top of the word space.
  assign w_nxt_tag = w_cur_tag + TW'(1);

  assign w_hit0    = r_valid[0] && (r_tag[0] == w_cur_tag);
  assign w_hit1    = r_valid[1] && (r_tag[1] == w_cur_tag);
  assign w_hit     = w_hit0 || w_hit1;
  assign w_hit_idx = !w_hit0;
  assign w_nxt_in  = (r_valid[0] && (r_tag[0] == w_nxt_tag)) ||
                     (r_valid[1] && (r_tag[1] == w_nxt_tag));

  // ok_r only counts while the address it was computed for is still presented.
  assign w_scr_ok  = r_ok && (r_addr_l == bus.scr_addr);
  assign w_miss    = bus.scr_cs && !w_hit;

  // The first cycle after rom_cs rises may carry a stale rom_ok from the
  // previous access, so it is never accepted.
  assign w_ack     = (r_state != IDLE) && !r_first && bus.rom_ok;
  assign w_fill    = w_ack && !r_discard && !bus.flush;

  // A prefetch must not evict the word the reader is currently using.
  assign w_victim  = ((r_state == PREF) && w_hit && (w_hit_idx == r_lru)) ? !r_lru : r_lru;

  assign w_hit_word = w_hit0 ? r_word[0] : r_word[1];

  always_comb begin
    w_byte = w_hit_word[7:0];
    case (bus.scr_addr[1:0])
      2'd0:    w_byte = w_hit_word[7:0];
      2'd1:    w_byte = w_hit_word[15:8];
      2'd2:    w_byte = w_hit_word[23:16];
      2'd3:    w_byte = w_hit_word[31:24];
      default: w_byte = w_hit_word[7:0];
    endcase
  end

  always_comb begin
    w_state_nx   = r_state;
    w_start      = 1'b0;
    w_start_addr = r_rom_addr;
    case (r_state)
      IDLE: begin
        if (w_miss) begin
          w_state_nx   = FETCH;
          w_start      = 1'b1;
          w_start_addr = w_cur_tag;
        end else if ((PREFETCH != 0) && bus.scr_cs && w_scr_ok && !w_nxt_in) begin
          w_state_nx   = PREF;
          w_start      = 1'b1;
          w_start_addr = w_nxt_tag;
        end
      end
      FETCH, PREF: begin
        if (w_ack) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_valid    <= 2'b00;
      r_tag[0]   <= '0;
      r_tag[1]   <= '0;
      r_word[0]  <= '0;
      r_word[1]  <= '0;
      r_lru      <= 1'b0;
      r_rom_cs   <= 1'b0;
      r_rom_addr <= '0;
      r_scr_data <= '0;
      r_ok       <= 1'b0;
      r_addr_l   <= '0;
      r_first    <= 1'b0;
      r_discard  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_addr_l <= bus.scr_addr;
      r_first  <= w_start;

      if (w_start) begin
        r_rom_cs   <= 1'b1;
        r_rom_addr <= w_start_addr;
      end else if (w_ack) begin
        r_rom_cs   <= 1'b0;
      end

      // A flush seen at any point of an access poisons its fill.
      if (w_state_nx == IDLE)
        r_discard <= 1'b0;
      else if (bus.flush)
        r_discard <= 1'b1;

      if (bus.flush) begin
        r_ok <= 1'b0;
      end else if (bus.scr_cs && w_hit) begin
        r_ok       <= 1'b1;
        r_scr_data <= w_byte;
      end else begin
        r_ok <= 1'b0;
      end

      if (bus.flush)
        r_valid <= 2'b00;
      else if (w_fill)
        r_valid[w_victim] <= 1'b1;

      if (w_fill) begin
        r_tag[w_victim]  <= r_rom_addr;
        r_word[w_victim] <= bus.rom_data;
      end

      if (w_fill)
        r_lru <= !r_lru;
      else if (bus.scr_cs && w_hit)
        r_lru <= !w_hit_idx;
    end
  end

  assign bus.scr_data = r_scr_data;
  assign bus.scr_ok   = w_scr_ok;
  assign bus.rom_cs   = r_rom_cs;
  assign bus.rom_addr = r_rom_addr;

endmodule
